spdif_frame_sequencer: RTL

SPDIF_FRAME_SEQUENCER -- requirements
Module: spdif_frame_sequencer

---
 rtl/spdif_frame_sequencer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/spdif_frame_sequencer.sv
// ----------------------------------------------------------------------------
// spdif_frame_sequencer
//
// Tracks the S/PDIF B/M/W preamble sequence of decoded subframes. It pairs
// left (B/M) and right (W) subframes into stereo samples, keeps frame count
// within the 192-frame block, and captures the first 32 left-channel C bits
// as the channel-status word.
//
// Optional feature macro: SPDIF_PARITY_CHECK_EN
//   When defined, a subframe with odd parity over sf_data and sf_vucp counts
//   as a sequence error. When undefined, the P bit is ignored.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   sf_valid    one-cycle strobe, a decoded subframe is present
//   sf_pre      preamble type: 0=B, 1=M, 2=W, 3=invalid
//   sf_data     audio sample bits 4..27
//   sf_vucp     {V,U,C,P} bits 28..31
//   smp_valid   stereo pair available (valid/ready handshake)
//   smp_ready   downstream accepts the pair
//   smp_l/smp_r left / right sample of the held pair
//   locked      LOCK_FRAMES consecutive good frames have been seen
//   frame_idx   current frame number in the block, 0..191
//   cs_word     first 32 left-channel C bits, bit n = frame n
//   cs_strobe   one-cycle pulse when cs_word updates
//   err_cnt     saturating count of sequence/parity errors
//   overrun     sticky, a completed pair was dropped
// ----------------------------------------------------------------------------
module spdif_frame_sequencer #(
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sf_valid,
    input  logic [1:0]  sf_pre,
    input  logic [23:0] sf_data,
    input  logic [3:0]  sf_vucp,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic [23:0] smp_l,
    output logic [23:0] smp_r,
    output logic        locked,
    output logic [7:0]  frame_idx,
    output logic [31:0] cs_word,
    output logic        cs_strobe,
    output logic [7:0]  err_cnt,
    output logic        overrun
);

    localparam logic [1:0] PRE_B = 2'd0;
    localparam logic [1:0] PRE_M = 2'd1;
    localparam logic [1:0] PRE_W = 2'd2;

    localparam logic [7:0] LAST_FRAME = 8'd191;
    localparam logic [7:0] CS_FRAMES  = 8'd32;

    localparam int GW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_FRAMES);
    localparam logic [GW-1:0] GOOD_PRE = GW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        EXP_W  = 2'd1,
        EXP_MB = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [7:0]    idx_next;
    logic          latch_left;
    logic          pair_done;
    logic          seq_err;
    logic          par_err;
    logic [23:0]   left_hold;
    logic [31:0]   shadow;
    logic [GW-1:0] good_cnt;
    logic          c_bit;

    assign c_bit = sf_vucp[1];

`ifdef SPDIF_PARITY_CHECK_EN
    assign par_err = ^{sf_data, sf_vucp};
`else
    // V, U and P carry no meaning for sequencing without the parity check.
    logic unused_vucp;
    assign unused_vucp = ^{sf_vucp[3:2], sf_vucp[0]};
    assign par_err     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state / decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        idx_next   = frame_idx;
        latch_left = 1'b0;
        pair_done  = 1'b0;
        seq_err    = 1'b0;

        if (sf_valid) begin
            if (par_err) begin
                seq_err = 1'b1;
            end else begin
                case (state)
                    HUNT: begin
                        // Only a block start gets us out of hunting; everything
                        // else is silently ignored.
                        if (sf_pre == PRE_B) begin
                            state_next = EXP_W;
                            idx_next   = 8'd0;
                            latch_left = 1'b1;
                        end
                    end
                    EXP_W: begin
                        if (sf_pre == PRE_W) begin
                            state_next = EXP_MB;
                            pair_done  = 1'b1;
                        end else begin
                            seq_err = 1'b1;
                        end
                    end
                    EXP_MB: begin
                        if (sf_pre == PRE_M && frame_idx != LAST_FRAME) begin
                            state_next = EXP_W;
                            idx_next   = frame_idx + 8'd1;
                            latch_left = 1'b1;
                        end else if (sf_pre == PRE_B && frame_idx == LAST_FRAME) begin
                            state_next = EXP_W;
                            idx_next   = 8'd0;
                            latch_left = 1'b1;
                        end else begin
                            seq_err = 1'b1;
                        end
                    end
                    default: state_next = HUNT;
                endcase
            end

            // An offending B is still a plausible block start, so restart
            // on it directly instead of waiting for the next one.
            if (seq_err) begin
                idx_next = 8'd0;
                if (sf_pre == PRE_B) begin
                    state_next = EXP_W;
                    latch_left = 1'b1;
                end else begin
                    state_next = HUNT;
                    latch_left = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State, sample path, status
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= HUNT;
            frame_idx <= '0;
            left_hold <= '0;
            smp_valid <= 1'b0;
            smp_l     <= '0;
            smp_r     <= '0;
            locked    <= 1'b0;
            good_cnt  <= '0;
            cs_word   <= '0;
            shadow    <= '0;
            cs_strobe <= 1'b0;
            err_cnt   <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            frame_idx <= idx_next;
            cs_strobe <= 1'b0;

            if (seq_err) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                good_cnt  <= '0;
                locked    <= 1'b0;
                left_hold <= '0;
                shadow    <= '0;
            end

            // Later bit write overrides the error clear for the restart B.
            if (latch_left) begin
                left_hold <= sf_data;
                if (idx_next < CS_FRAMES) shadow[idx_next[4:0]] <= c_bit;
            end

            if (pair_done) begin
                if (good_cnt != GOOD_MAX) good_cnt <= good_cnt + 1'b1;
                // good_cnt saturates, so this also holds locked once reached.
                if (good_cnt >= GOOD_PRE) locked <= 1'b1;
                if (frame_idx == CS_FRAMES - 8'd1) begin
                    cs_word   <= shadow;
                    cs_strobe <= 1'b1;
                end
            end

            // Output slot: a new pair may replace one leaving in the same
            // cycle; a pair arriving against a stalled slot is dropped.
            if (pair_done && (!smp_valid || smp_ready)) begin
                smp_valid <= 1'b1;
                smp_l     <= left_hold;
                smp_r     <= sf_data;
            end else if (pair_done) begin
                overrun <= 1'b1;
            end else if (smp_valid && smp_ready) begin
                smp_valid <= 1'b0;
            end
        end
    end

endmodule
